// File: rtl/rbe_periph_driver.sv
// Periph-port master that runs one RBE job per descriptor: ACQUIRE, job register writes, TRIGGER, wait for event.
// Optional watchdog with SOFT_CLEAR recovery: define RBE_PERIPH_DRIVER_WATCHDOG_EN.
module rbe_periph_driver #(
  parameter int unsigned          ID_WIDTH   = 8,
  parameter int unsigned          N_JOB_REGS = 16,
  parameter logic [31:0]          BASE_ADDR  = 32'h0,
  parameter int unsigned          RETRY_WAIT = 4,
  parameter int unsigned          TIMEOUT    = 65535,
  parameter logic [ID_WIDTH-1:0]  MY_ID      = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  output logic                     periph_req_o,
  input  logic                     periph_gnt_i,
  output logic [31:0]              periph_add_o,
  output logic                     periph_wen_o,
  output logic [3:0]               periph_be_o,
  output logic [31:0]              periph_data_o,
  output logic [ID_WIDTH-1:0]      periph_id_o,
  input  logic                     periph_r_valid_i,
  input  logic [31:0]              periph_r_data_i,
  input  logic [ID_WIDTH-1:0]      periph_r_id_i,
  input  logic                     evt_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [7:0]               job_id_o,
  output logic                     error_o
);

  localparam int unsigned IDX_W = $clog2(N_JOB_REGS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_JOB_REGS - 1);
  localparam logic [31:0] OFS_TRIGGER    = 32'h00;
  localparam logic [31:0] OFS_ACQUIRE    = 32'h04;
  localparam logic [31:0] OFS_SOFT_CLEAR = 32'h14;
  localparam logic [31:0] OFS_JOB        = 32'h40;

  typedef enum logic [3:0] {
    IDLE, ACQ_REQ, ACQ_WAIT, ACQ_BACKOFF, WR_REGS, TRIG, WAIT_EVT, DONE
`ifdef RBE_PERIPH_DRIVER_WATCHDOG_EN
    , CLR
`endif
  } state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         idx;
  logic [31:0]              bo_cnt;
  logic [N_JOB_REGS*32-1:0] regs_q;
  logic [7:0]               job_id_q;

  // Response ID and the unused read-data bits carry nothing this master needs.
  logic unused_in;
  assign unused_in = ^{periph_r_id_i, periph_r_data_i[30:8]};

  assign periph_be_o = 4'hF;
  assign periph_id_o = MY_ID;
  assign job_ready_o = (state == IDLE) && !rst_i;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign job_id_o    = job_id_q;

`ifdef RBE_PERIPH_DRIVER_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        err_q;
  assign error_o = err_q;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
  assign error_o = 1'b0;
`endif

  // Outputs below depend only on state/idx/regs, so they hold while a request is stalled.
  always_comb begin
    state_nxt     = state;
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b0;
    periph_data_o = '0;
    case (state)
      IDLE:        if (job_valid_i) state_nxt = ACQ_REQ;
      ACQ_REQ: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + OFS_ACQUIRE;
        periph_wen_o = 1'b1;
        if (periph_gnt_i) state_nxt = ACQ_WAIT;
      end
      ACQ_WAIT:    if (periph_r_valid_i) state_nxt = periph_r_data_i[31] ? ACQ_BACKOFF : WR_REGS;
      ACQ_BACKOFF: if (bo_cnt + 32'd1 >= RETRY_WAIT) state_nxt = ACQ_REQ;
      WR_REGS: begin
        periph_req_o  = 1'b1;
        periph_add_o  = BASE_ADDR + OFS_JOB + 32'({idx, 2'b00});
        periph_data_o = regs_q[{idx[IDX_W-2:0], 5'b0} +: 32];
        if (periph_gnt_i && idx == LAST_IDX) state_nxt = TRIG;
      end
      TRIG: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + OFS_TRIGGER;
        if (periph_gnt_i) state_nxt = WAIT_EVT;
      end
      WAIT_EVT: begin
        if (evt_i) state_nxt = DONE;
`ifdef RBE_PERIPH_DRIVER_WATCHDOG_EN
        else if (wd_cnt + 32'd1 == TIMEOUT) state_nxt = CLR;
`endif
      end
      DONE:        state_nxt = IDLE;
`ifdef RBE_PERIPH_DRIVER_WATCHDOG_EN
      CLR: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + OFS_SOFT_CLEAR;
        if (periph_gnt_i) state_nxt = DONE;
      end
`endif
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      bo_cnt   <= '0;
      regs_q   <= '0;
      job_id_q <= '0;
    end else begin
      state  <= state_nxt;
      bo_cnt <= (state == ACQ_BACKOFF) ? bo_cnt + 32'd1 : 32'd0;
      if (state == IDLE && job_valid_i) regs_q <= job_regs_i;
      if (state == ACQ_WAIT && periph_r_valid_i && !periph_r_data_i[31]) begin
        job_id_q <= periph_r_data_i[7:0];
        idx      <= '0;
      end
      if (state == WR_REGS && periph_gnt_i) idx <= idx + 1'b1;
    end
  end

`ifdef RBE_PERIPH_DRIVER_WATCHDOG_EN
  // wd_cnt is the number of cycles since the trigger write was accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == TRIG && periph_gnt_i) || state == WAIT_EVT) wd_cnt <= wd_cnt + 32'd1;
      else wd_cnt <= '0;
      if (state == IDLE && job_valid_i) err_q <= 1'b0;
      else if (state == CLR && periph_gnt_i) err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rbe_periph_driver.sv
// Directed bench for rbe_periph_driver with a one-outstanding periph target model.
module tb_rbe_periph_driver;
  localparam int N = 16;
  localparam int RW = 4;
  localparam int TMO = 100;

  logic clk = 0, rst_i = 1;
  logic job_valid_i = 0, job_ready_o;
  logic [N*32-1:0] job_regs_i = '0;
  logic periph_req_o, periph_gnt_i = 0, periph_wen_o;
  logic [31:0] periph_add_o, periph_data_o;
  logic [3:0] periph_be_o;
  logic [7:0] periph_id_o, periph_r_id_i = 0;
  logic periph_r_valid_i = 0;
  logic [31:0] periph_r_data_i = 0;
  logic evt_i = 0, busy_o, done_o, error_o;
  logic [7:0] job_id_o;

  rbe_periph_driver #(.ID_WIDTH(8), .N_JOB_REGS(N), .BASE_ADDR(32'h0), .RETRY_WAIT(RW),
                      .TIMEOUT(TMO), .MY_ID(8'h5A)) dut (
    .clk_i(clk), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_regs_i(job_regs_i), .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i),
    .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o),
    .periph_data_o(periph_data_o), .periph_id_o(periph_id_o),
    .periph_r_valid_i(periph_r_valid_i), .periph_r_data_i(periph_r_data_i),
    .periph_r_id_i(periph_r_id_i), .evt_i(evt_i), .busy_o(busy_o), .done_o(done_o),
    .job_id_o(job_id_o), .error_o(error_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] add; logic wen; logic [31:0] data; int cyc; } tr_t;
  tr_t tr_q[$];
  logic [31:0] acq_q[$];
  int total = 0, bad = 0;
  int done_n = 0, done_cyc = 0, hold_chk = 0, hold_bad = 0, hs_cyc = 0;
  logic [7:0] done_jid = 0;
  bit gnt_rand = 0, rd_pend = 0, hold_pend = 0;
  logic [31:0] rd_pend_data = 0, h_add = 0, h_data = 0;
  logic h_wen = 0;

  // Target model: grant decided per cycle, response one cycle after each granted transaction.
  always @(negedge clk) begin
    if (rst_i) begin
      periph_r_valid_i = 0; rd_pend = 0; hold_pend = 0;
    end else begin
      periph_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      periph_r_valid_i = rd_pend;
      periph_r_data_i = rd_pend_data;
      rd_pend = 0;
      if (hold_pend) begin
        hold_chk++;
        if (!periph_req_o || periph_add_o !== h_add || periph_wen_o !== h_wen || periph_data_o !== h_data)
          hold_bad++;
      end
      hold_pend = 0;
      if (periph_req_o) begin
        if (periph_gnt_i) begin
          tr_q.push_back(tr_t'{periph_add_o, periph_wen_o, periph_data_o, cyc});
          rd_pend = 1;
          if (periph_wen_o) rd_pend_data = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
          else rd_pend_data = 32'hFFFF_FFFF;
        end else begin
          hold_pend = 1; h_add = periph_add_o; h_wen = periph_wen_o; h_data = periph_data_o;
        end
      end
      if (done_o) begin done_n++; done_cyc = cyc; done_jid = job_id_o; end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send_job(input logic [N*32-1:0] r);
    int n = 0;
    tr_q.delete(); done_n = 0;
    job_regs_i = r; job_valid_i = 1;
    while (!job_ready_o && n < 200) begin tick(); n++; end
    total++;
    if (!job_ready_o) begin bad++; $display("FAIL handshake_timeout ready=%0b need=1", job_ready_o); end
    tick();
    job_valid_i = 0; hs_cyc = cyc;
  endtask

  task automatic wait_tr(input int k, output bit ok);
    int n = 0;
    while (tr_q.size() < k && n < 2000) begin tick(); n++; end
    ok = (tr_q.size() >= k);
    if (!ok) begin total++; bad++; $display("FAIL wait_tr got=%0d need=%0d", tr_q.size(), k); end
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_n == 0 && n < 2000) begin tick(); n++; end
    ok = (done_n > 0);
    if (!ok) begin total++; bad++; $display("FAIL wait_done got=0 need=1"); end
  endtask

  task automatic pulse_evt(); evt_i = 1; tick(); evt_i = 0; endtask

  task automatic test_reset();
    #2;
    total++;
    if ({periph_req_o, periph_be_o, periph_id_o, busy_o, done_o, job_id_o, error_o, job_ready_o,
         periph_add_o, periph_wen_o, periph_data_o} !== {1'b0, 4'hF, 8'h5A, 1'b0, 1'b0, 8'h0, 1'b0,
         1'b0, 32'h0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_outputs req=%0b be=%h id=%h busy=%0b done=%0b jid=%h err=%0b rdy=%0b",
                      periph_req_o, periph_be_o, periph_id_o, busy_o, done_o, job_id_o, error_o, job_ready_o);
    end
    tick(); rst_i = 0; #1;
    total++;
    if (job_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%0b need=1", job_ready_o); end
  endtask

  task automatic test_nominal();
    logic [N*32-1:0] r;
    bit ok;
    int t;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = 32'hA000 + i;
    acq_q = {32'd3};
    send_job(r);
    total++;
    if (busy_o !== 1 || job_ready_o !== 0) begin
      bad++; $display("FAIL nom_busy busy=%0b rdy=%0b need busy=1 rdy=0", busy_o, job_ready_o);
    end
    wait_tr(18, ok); if (!ok) return;
    total++;
    if (tr_q[0].add !== 32'h4 || tr_q[0].wen !== 1 || tr_q[0].cyc != hs_cyc) begin
      bad++; $display("FAIL nom_acq add=%h wen=%0b cyc=%0d need add=4 wen=1 cyc=%0d",
                      tr_q[0].add, tr_q[0].wen, tr_q[0].cyc, hs_cyc);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (tr_q[1+i].add !== 32'h40 + 4*i || tr_q[1+i].wen !== 0 || tr_q[1+i].data !== 32'hA000 + i
          || tr_q[1+i].cyc != hs_cyc + 2 + i) begin
        bad++; $display("FAIL nom_wr%0d add=%h data=%h cyc=%0d need add=%h data=%h cyc=%0d", i,
                        tr_q[1+i].add, tr_q[1+i].data, tr_q[1+i].cyc, 32'h40 + 4*i, 32'hA000 + i, hs_cyc + 2 + i);
      end
    end
    t = tr_q[17].cyc;
    total++;
    if (tr_q[17].add !== 32'h0 || tr_q[17].wen !== 0 || tr_q[17].data !== 0 || t != hs_cyc + 18) begin
      bad++; $display("FAIL nom_trig add=%h data=%h cyc=%0d need add=0 data=0 cyc=%0d",
                      tr_q[17].add, tr_q[17].data, t, hs_cyc + 18);
    end
    while (cyc < t + 20) tick();
    total++;
    if (busy_o !== 1 || done_n != 0 || periph_id_o !== 8'h5A) begin
      bad++; $display("FAIL nom_wait busy=%0b dones=%0d id=%h need busy=1 dones=0 id=5a", busy_o, done_n, periph_id_o);
    end
    pulse_evt();
    tick();
    total++;
    if (done_n != 1 || done_cyc != t + 21 || done_jid !== 8'd3) begin
      bad++; $display("FAIL nom_done n=%0d cyc=%0d jid=%0d need n=1 cyc=%0d jid=3", done_n, done_cyc, done_jid, t + 21);
    end
    total++;
    if (job_ready_o !== 1 || busy_o !== 0 || error_o !== 0 || tr_q.size() != 18) begin
      bad++; $display("FAIL nom_after rdy=%0b busy=%0b err=%0b trs=%0d need 1 0 0 18",
                      job_ready_o, busy_o, error_o, tr_q.size());
    end
  endtask

  task automatic test_busy_retry();
    logic [N*32-1:0] r = '0;
    bit ok;
    acq_q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    send_job(r);
    wait_tr(20, ok); if (!ok) return;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (tr_q[k].add !== 32'h4 || tr_q[k].wen !== 1) begin
        bad++; $display("FAIL retry_rd%0d add=%h wen=%0b need add=4 wen=1", k, tr_q[k].add, tr_q[k].wen);
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (tr_q[k+1].cyc - tr_q[k].cyc - 1 < RW) begin
        bad++; $display("FAIL retry_gap%0d idle=%0d need>=%0d", k, tr_q[k+1].cyc - tr_q[k].cyc - 1, RW);
      end
    end
    total++;
    if (tr_q[3].add !== 32'h40 || tr_q[3].wen !== 0) begin
      bad++; $display("FAIL retry_reads add=%h need 40 (exactly 3 reads)", tr_q[3].add);
    end
    pulse_evt();
    wait_done(ok); if (!ok) return;
    total++;
    if (done_jid !== 8'd0) begin bad++; $display("FAIL retry_jid got=%0d need=0", done_jid); end
  endtask

  task automatic test_grant_stall();
    logic [N*32-1:0] r;
    bit ok, good;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = $urandom;
    acq_q = {32'd7};
    hold_chk = 0; hold_bad = 0; gnt_rand = 1;
    send_job(r);
    wait_tr(18, ok);
    gnt_rand = 0;
    if (!ok) return;
    total++;
    if (hold_bad != 0 || hold_chk == 0) begin
      bad++; $display("FAIL stall_hold viol=%0d stalls=%0d need viol=0 stalls>0", hold_bad, hold_chk);
    end
    good = 1;
    for (int i = 0; i < N; i++)
      if (tr_q[1+i].add !== 32'h40 + 4*i || tr_q[1+i].data !== r[i*32 +: 32]) good = 0;
    total++;
    if (!good || tr_q[17].add !== 32'h0) begin
      bad++; $display("FAIL stall_order regs_ok=%0b trig_add=%h need 1 0", good, tr_q[17].add);
    end
    pulse_evt();
    wait_done(ok); if (!ok) return;
    total++;
    if (done_jid !== 8'd7 || tr_q.size() != 18) begin
      bad++; $display("FAIL stall_done jid=%0d trs=%0d need 7 18", done_jid, tr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [N*32-1:0] r;
    bit ok;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = 32'hB000 + i;
    acq_q = {32'd2};
    send_job(r);
    wait_tr(6, ok); if (!ok) return;
    total++;
    if (periph_req_o !== 1) begin bad++; $display("FAIL rstmid_pre req=%0b need=1", periph_req_o); end
    rst_i = 1; #1;
    total++;
    if (periph_req_o !== 0 || busy_o !== 0) begin
      bad++; $display("FAIL rstmid_drop req=%0b busy=%0b need 0 0", periph_req_o, busy_o);
    end
    tick(); rst_i = 0; tick();
    acq_q = {32'd9};
    send_job(r);
    wait_tr(18, ok); if (!ok) return;
    total++;
    if (tr_q[0].add !== 32'h4 || tr_q[0].wen !== 1 || tr_q[1].add !== 32'h40 || tr_q[1].data !== 32'hB000) begin
      bad++; $display("FAIL rstmid_restart a0=%h w0=%0b a1=%h d1=%h need 4 1 40 b000",
                      tr_q[0].add, tr_q[0].wen, tr_q[1].add, tr_q[1].data);
    end
    pulse_evt();
    wait_done(ok); if (!ok) return;
    total++;
    if (done_jid !== 8'd9) begin bad++; $display("FAIL rstmid_jid got=%0d need=9", done_jid); end
  endtask

  task automatic test_spurious_evt();
    logic [N*32-1:0] r = '1;
    bit ok;
    done_n = 0;
    pulse_evt(); tick(); tick(); tick();
    total++;
    if (done_n != 0 || busy_o !== 0) begin
      bad++; $display("FAIL spur_idle dones=%0d busy=%0b need 0 0", done_n, busy_o);
    end
    acq_q = {32'd1};
    send_job(r);
    wait_tr(4, ok); if (!ok) return;
    pulse_evt();
    wait_tr(18, ok); if (!ok) return;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (done_n != 0 || busy_o !== 1) begin
      bad++; $display("FAIL spur_wr dones=%0d busy=%0b need 0 1", done_n, busy_o);
    end
    pulse_evt();
    wait_done(ok); if (!ok) return;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (done_n != 1 || done_jid !== 8'd1) begin
      bad++; $display("FAIL spur_real dones=%0d jid=%0d need 1 1", done_n, done_jid);
    end
  endtask

`ifdef RBE_PERIPH_DRIVER_WATCHDOG_EN
  task automatic test_watchdog();
    logic [N*32-1:0] r = '0;
    bit ok;
    int t;
    acq_q = {32'd4};
    send_job(r);
    wait_tr(18, ok); if (!ok) return;
    t = tr_q[17].cyc;
    while (cyc < t + 50) tick();
    total++;
    if (error_o !== 0 || done_n != 0) begin
      bad++; $display("FAIL wd_early err=%0b dones=%0d need 0 0", error_o, done_n);
    end
    wait_tr(19, ok); if (!ok) return;
    total++;
    if (tr_q[18].add !== 32'h14 || tr_q[18].wen !== 0 || tr_q[18].data !== 0 || tr_q[18].cyc != t + TMO) begin
      bad++; $display("FAIL wd_clear add=%h data=%h cyc=%0d need 14 0 %0d",
                      tr_q[18].add, tr_q[18].data, tr_q[18].cyc, t + TMO);
    end
    wait_done(ok); if (!ok) return;
    total++;
    if (error_o !== 1 || done_n != 1 || done_cyc != t + TMO + 1) begin
      bad++; $display("FAIL wd_done err=%0b dones=%0d cyc=%0d need 1 1 %0d", error_o, done_n, done_cyc, t + TMO + 1);
    end
    tick();
    acq_q = {32'd5};
    send_job(r);
    total++;
    if (error_o !== 0) begin bad++; $display("FAIL wd_clear_err got=%0b need=0", error_o); end
    wait_tr(18, ok); if (!ok) return;
    pulse_evt();
    wait_done(ok); if (!ok) return;
    total++;
    if (done_jid !== 8'd5 || error_o !== 0) begin
      bad++; $display("FAIL wd_next jid=%0d err=%0b need 5 0", done_jid, error_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_busy_retry();
    test_grant_stall();
    test_reset_mid();
    test_spurious_evt();
`ifdef RBE_PERIPH_DRIVER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1);
  end
endmodule
